// File: rtl/usr_seq.sv
// usr_seq: parametrised universal shift register.
// Single-cycle NOP/LOAD/CLR, plus shift-class ops (SHL, SHR, ROL, ROR, ASR)
// that are sequenced one bit per falling clock edge with a busy/done handshake.

module usr_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   par_in,
  input  logic               ser_in_l,
  input  logic               ser_in_r,
  output logic [WIDTH-1:0]   q,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  // Command codes
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  // Register width expressed in the shift-amount width, used for clamping.
  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] ONE_C   = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] ZERO_C  = SHAMT_W'(0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 ser_q, ser_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2:0]           op_q, op_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;

  logic [SHAMT_W-1:0]   n_eff_s;
  logic [WIDTH:0]       step_idle_s;
  logic [WIDTH:0]       step_shift_s;

  // True for the ops that move bits one position per step.
  function automatic logic is_shift_op(input logic [2:0] o);
    logic r;
    case (o)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // One single-bit step: returns {ejected/wrapped bit, new register value}.
  function automatic logic [WIDTH:0] shift_step(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] v,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH:0] r;
    case (o)
      OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], sr};
      OP_SHR:  r = {v[0], sl, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  // Clamp the requested amount to the register width.
  always_comb begin
    if (shamt > WIDTH_C) begin
      n_eff_s = WIDTH_C;
    end else begin
      n_eff_s = shamt;
    end
  end

  // Step results for a fresh command (live op) and for an ongoing shift (latched op).
  always_comb begin
    step_idle_s  = shift_step(op,   q_q, ser_in_l, ser_in_r);
    step_shift_s = shift_step(op_q, q_q, ser_in_l, ser_in_r);
  end

  // Next-state and datapath decode; every register holds unless a case below changes it.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ser_d   = ser_q;
    op_d    = op_q;
    rem_d   = rem_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(op)) begin
            if (n_eff_s == ZERO_C) begin
              // Zero-length shift: nothing moves, ser_out holds.
              done_d = 1'b1;
            end else begin
              // First step happens on the accepting edge.
              ser_d = step_idle_s[WIDTH];
              q_d   = step_idle_s[WIDTH-1:0];
              op_d  = op;
              rem_d = n_eff_s - ONE_C;
              if (n_eff_s != ONE_C) begin
                state_d = ST_SHIFT;
                busy_d  = 1'b1;
              end else begin
                done_d = 1'b1;
              end
            end
          end else begin
            case (op)
              OP_LOAD: q_d = par_in;
              OP_CLR:  q_d = {WIDTH{1'b0}};
              default: q_d = q_q;
            endcase
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        ser_d = step_shift_s[WIDTH];
        q_d   = step_shift_s[WIDTH-1:0];
        rem_d = rem_q - ONE_C;
        if (rem_q == ONE_C) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        rem_d   = ZERO_C;
      end
    endcase
  end

  // State and output registers; all updates happen on the falling clock edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= {WIDTH{1'b0}};
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_NOP;
      rem_q   <= ZERO_C;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

  usr_seq_chk #(.SHAMT_W(SHAMT_W)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy_q),
    .done     (done_q),
    .in_shift (state_q == ST_SHIFT),
    .rem      (rem_q)
  );

endmodule

// usr_seq_chk: handshake invariants of the sequencer.
module usr_seq_chk #(
  parameter int SHAMT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               busy,
  input logic               done,
  input logic               in_shift,
  input logic [SHAMT_W-1:0] rem
);

  // done and busy are mutually exclusive.
  a_done_busy_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));

  // busy mirrors the SHIFT state.
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy == in_shift);

  // While shifting there is always at least one step left.
  a_rem_nonzero: assert property (@(posedge clk) disable iff (!rst_n) !in_shift || (rem != '0));

endmodule

// File: tb/tb_usr_seq.sv
// Scoreboard bench for usr_seq (WIDTH=8, SHAMT_W=4). Expected results are pushed
// when a command is issued; a monitor pops and compares on every done pulse.

module tb_usr_seq;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] SHL  = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] LOAD = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] ASR  = 3'b110;
  localparam logic [2:0] CLR  = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] shamt;
  logic [7:0] par_in;
  logic       ser_in_l;
  logic       ser_in_r;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       ser;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   busy_run = 0;

  usr_seq #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .par_in   (par_in),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [7:0] eq, input logic es, input int eb);
    exp_t e;
    e.name = name;
    e.q = eq;
    e.ser = es;
    e.busy_cycles = eb;
    sb.push_back(e);
  endtask

  // Monitor: sampled on the rising edge, halfway between active (falling) edges.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done && busy) begin
        chk("done_busy_overlap", 32'd1, 32'd0);
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_q"}, {24'd0, q}, {24'd0, e.q});
          chk({e.name, "_ser"}, {31'd0, ser_out}, {31'd0, e.ser});
          chk({e.name, "_busy_cycles"}, busy_run, e.busy_cycles);
        end
        busy_run = 0;
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [3:0] sa, input logic [7:0] p,
                      input logic sl, input logic sr);
    @(posedge clk);
    #1;
    start = 1'b1; op = o; shamt = sa; par_in = p; ser_in_l = sl; ser_in_r = sr;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; op = NOP; shamt = 4'd0; par_in = 8'h00;
    ser_in_l = 1'b0; ser_in_r = 1'b0;
    #3;
    chk("reset_q", {24'd0, q}, 32'h0);
    chk("reset_ser", {31'd0, ser_out}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_done", {31'd0, done}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    push("load_a5", 8'hA5, 1'b0, 0); send(LOAD, 4'd0, 8'hA5, 1'b0, 1'b0); wait_done(1);
    push("shl3",    8'h2F, 1'b1, 2); send(SHL,  4'd3, 8'h00, 1'b0, 1'b1); wait_done(2);
    push("load_96", 8'h96, 1'b1, 0); send(LOAD, 4'd0, 8'h96, 1'b0, 1'b0); wait_done(3);
    push("asr2",    8'hE5, 1'b1, 1); send(ASR,  4'd2, 8'h00, 1'b1, 1'b1); wait_done(4);
    push("load_96b",8'h96, 1'b1, 0); send(LOAD, 4'd0, 8'h96, 1'b0, 1'b0); wait_done(5);
    push("shr2",    8'h25, 1'b1, 1); send(SHR,  4'd2, 8'h00, 1'b0, 1'b1); wait_done(6);
    push("load_3c", 8'h3C, 1'b1, 0); send(LOAD, 4'd0, 8'h3C, 1'b0, 1'b0); wait_done(7);
    push("ror12",   8'h3C, 1'b0, 7); send(ROR,  4'd12, 8'h00, 1'b1, 1'b1); wait_done(8);

    // Mid-shift start is ignored.
    push("load_01", 8'h01, 1'b0, 0); send(LOAD, 4'd0, 8'h01, 1'b0, 1'b0); wait_done(9);
    push("shl5_ign",8'h20, 1'b0, 4); send(SHL,  4'd5, 8'h00, 1'b0, 1'b0);
    @(negedge clk); #1;
    start = 1'b1; op = LOAD; par_in = 8'hFF;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(10);

    // Mid-shift reset aborts with no done pulse.
    push("load_01b",8'h01, 1'b0, 0); send(LOAD, 4'd0, 8'h01, 1'b0, 1'b0); wait_done(11);
    send(SHL, 4'd5, 8'h00, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_q", {24'd0, q}, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_done", {31'd0, done}, 32'h0);
    chk("abort_ser", {31'd0, ser_out}, 32'h0);
    @(negedge clk); @(posedge clk); #1; rst_n = 1'b1;
    base = done_cnt;
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", done_cnt, base);
    chk("sb_empty_after_abort", sb.size(), 0);

    // N=1 rotate behaves as single-cycle; zero shift holds ser_out; back-to-back CLR.
    push("load_81", 8'h81, 1'b0, 0); send(LOAD, 4'd0, 8'h81, 1'b0, 1'b0); wait_done(base + 1);
    push("rol1",    8'h03, 1'b1, 0); send(ROL,  4'd1, 8'h00, 1'b0, 1'b0); wait_done(base + 2);
    push("load_81b",8'h81, 1'b1, 0); send(LOAD, 4'd0, 8'h81, 1'b0, 1'b0); wait_done(base + 3);
    push("shl0",    8'h81, 1'b1, 0);
    push("clr_b2b", 8'h00, 1'b1, 0);
    send(SHL, 4'd0, 8'h00, 1'b0, 1'b0);
    start = 1'b1; op = CLR;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(base + 5);
    push("nop",     8'h00, 1'b1, 0); send(NOP,  4'd0, 8'h5A, 1'b1, 1'b1); wait_done(base + 6);

    repeat (3) @(negedge clk);
    chk("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
